gem_link_framer: RTL and testbench

- Parametrised successor to the trigger-link TX framer.
- Packs per-bunch-crossing cluster words for NUM_LINKS transceiver lanes into FRAME_WORDS x 16-bit 8b10b frames, running entirely in the transceiver user-clock domain.
- Adds a link bring-up state machine with an idle-training phase, per-link enable mask, upstream read handshake, and saturating status counters.
- Sits between the cluster CDC FIFO (first-word-fall-through, read side) and the transceiver wrapper data/charisk inputs.

---
 rtl/gem_link_framer.sv | 240 ++++++++++++++++++++++++
 tb/tb_gem_link_framer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gem_link_framer.sv
// ---------------------------------------------------------------------------
// gem_link_framer
//
// Packs per-bunch-crossing cluster words for NUM_LINKS transceiver lanes into
// FRAME_WORDS x 16-bit 8b10b frames. Everything runs in the transceiver user
// clock domain. A bring-up state machine sends IDLE_FRAMES idle frames after
// the transceivers report ready, then switches to data frames. The upstream
// first-word-fall-through FIFO is read with a single-cycle strobe and its word
// is captured at the end of that cycle.
//
// Ports
//   clock_160       in   transceiver user clock
//   reset_i         in   asynchronous reset, active-high
//   link_ready_i    in   transceivers ready (synchronous to clock_160)
//   link_en_i       in   per-lane data enable (disabled lanes send idle frames)
//   data_i          in   lane n cluster data at [n*DATA_BITS +: DATA_BITS]
//   bc0_i           in   BC0 flag, qualified with data_i
//   resync_i        in   resync flag, qualified with data_i
//   overflow_i      in   cluster overflow flag, qualified with data_i
//   bxn_lsbs_i      in   bunch-counter LSBs, qualified with data_i
//   data_rd_o       out  upstream FIFO read strobe
//   tx_data_o       out  lane n txdata at [n*16 +: 16]
//   tx_isk_o        out  lane n txcharisk at [n*2 +: 2]
//   state_o         out  0 = WAIT, 1 = TRAIN, 2 = RUN
//   frame_start_o   out  high while word 0 is on tx_data_o
//   overflow_cnt_o  out  saturating count of FC-separator frames sent
// ---------------------------------------------------------------------------
module gem_link_framer #(
  parameter int  NUM_LINKS       = 4,
  parameter int  FRAME_WORDS     = 4,
  parameter int  ALLOW_TTC_CHARS = 1,
  parameter int  FRAME_CTRL_TTC  = 1,
  parameter int  IDLE_FRAMES     = 16,
  localparam int DATA_BITS       = 16*FRAME_WORDS-8
) (
  input  logic                           clock_160,
  input  logic                           reset_i,
  input  logic                           link_ready_i,
  input  logic [NUM_LINKS-1:0]           link_en_i,
  input  logic [NUM_LINKS*DATA_BITS-1:0] data_i,
  input  logic                           bc0_i,
  input  logic                           resync_i,
  input  logic                           overflow_i,
  input  logic [1:0]                     bxn_lsbs_i,
  output logic                           data_rd_o,
  output logic [NUM_LINKS*16-1:0]        tx_data_o,
  output logic [NUM_LINKS*2-1:0]         tx_isk_o,
  output logic [1:0]                     state_o,
  output logic                           frame_start_o,
  output logic [15:0]                    overflow_cnt_o
);

  localparam int                WC_W      = $clog2(FRAME_WORDS);
  localparam logic [WC_W-1:0]   LAST_WORD = WC_W'(FRAME_WORDS-1);
  localparam logic [15:0]       IDLE_LAST = 16'(IDLE_FRAMES-1);

  typedef enum logic [1:0] {
    ST_WAIT  = 2'd0,
    ST_TRAIN = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  // K28.5 comma + D16.2, the standard idle ordered set, and the link-down word.
  localparam logic [15:0] IDLE_WORD0 = 16'h50BC;
  localparam logic [15:0] DOWN_WORD  = 16'hFFFC;

  // Separator character for word 0. TTC flags override the rotating
  // K-character selector; flag priority is bc0, then resync, then overflow.
  function automatic logic [7:0] sep_char(input logic       bc0,
                                          input logic       resync,
                                          input logic       ovf,
                                          input logic [1:0] sel);
    logic [7:0] c;
    case (sel)
      2'd0:    c = 8'hBC;
      2'd1:    c = 8'hF7;
      2'd2:    c = 8'hFB;
      default: c = 8'hFD;
    endcase
    if (ALLOW_TTC_CHARS != 0) begin
      if (bc0)         c = 8'h1C;
      else if (resync) c = 8'h3C;
      else if (ovf)    c = 8'hFC;
    end
    return c;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Control / output registers
  state_t                    state_q,        state_d;
  logic [WC_W-1:0]           word_cnt_q,     word_cnt_d;
  logic [15:0]               idle_cnt_q,     idle_cnt_d;
  logic [1:0]                frame_cnt_q,    frame_cnt_d;
  logic                      data_rd_q,      data_rd_d;
  logic                      frame_start_q,  frame_start_d;
  logic [15:0]               overflow_cnt_q, overflow_cnt_d;
  logic [NUM_LINKS*16-1:0]   tx_data_q,      tx_data_d;
  logic [NUM_LINKS*2-1:0]    tx_isk_q,       tx_isk_d;

  // Captured upstream word (data path, no reset needed)
  logic [NUM_LINKS*DATA_BITS-1:0] cap_data_q,     cap_data_d;
  logic                           cap_bc0_q,      cap_bc0_d;
  logic                           cap_resync_q,   cap_resync_d;
  logic                           cap_overflow_q, cap_overflow_d;
  logic [1:0]                     cap_bxn_q,      cap_bxn_d;

  logic                      frame_end;
  logic [1:0]                sep_sel;
  logic [7:0]                sep;
  logic [16*FRAME_WORDS-1:0] frame_bits;

  assign frame_end = (word_cnt_q == LAST_WORD);
  assign sep_sel   = (FRAME_CTRL_TTC != 0) ? cap_bxn_q : frame_cnt_q;
  assign sep       = sep_char(cap_bc0_q, cap_resync_q, cap_overflow_q, sep_sel);

  // Bring-up state machine, word counter and read strobe
  always_comb begin
    state_d     = state_q;
    word_cnt_d  = word_cnt_q;
    idle_cnt_d  = idle_cnt_q;
    frame_cnt_d = frame_cnt_q;

    if (!link_ready_i) begin
      // Link loss aborts immediately, even mid-frame.
      state_d    = ST_WAIT;
      word_cnt_d = '0;
    end else begin
      case (state_q)
        ST_WAIT: begin
          state_d    = ST_TRAIN;
          word_cnt_d = '0;
          idle_cnt_d = '0;
        end
        ST_TRAIN: begin
          word_cnt_d = frame_end ? '0 : word_cnt_q + 1'b1;
          if (frame_end) begin
            idle_cnt_d = idle_cnt_q + 16'd1;
            if (idle_cnt_q == IDLE_LAST) begin
              state_d     = ST_RUN;
              frame_cnt_d = '0;
            end
          end
        end
        ST_RUN: begin
          word_cnt_d = frame_end ? '0 : word_cnt_q + 1'b1;
          if (frame_end) frame_cnt_d = frame_cnt_q + 2'd1;
        end
        default: begin
          state_d    = ST_WAIT;
          word_cnt_d = '0;
        end
      endcase
    end

    // Strobe during the last word of any frame that is followed by a RUN
    // frame, including the final training frame.
    data_rd_d = (word_cnt_d == LAST_WORD) &&
                ((state_d == ST_RUN) ||
                 ((state_d == ST_TRAIN) && (idle_cnt_d == IDLE_LAST)));
  end

  // Frame assembly: word k of the current frame is registered while
  // word_cnt_q = k, so it appears on the outputs one cycle later.
  always_comb begin
    tx_data_d      = {NUM_LINKS{DOWN_WORD}};
    tx_isk_d       = {NUM_LINKS{2'b01}};
    frame_start_d  = 1'b0;
    overflow_cnt_d = overflow_cnt_q;
    frame_bits     = '0;

    if (link_ready_i && (state_q != ST_WAIT)) begin
      frame_start_d = (word_cnt_q == '0);
      for (int l = 0; l < NUM_LINKS; l++) begin
        if ((state_q == ST_RUN) && link_en_i[l]) begin
          // The frame is {data, sep} cut into 16-bit words, low word first.
          frame_bits            = {cap_data_q[l*DATA_BITS +: DATA_BITS], sep};
          tx_data_d[l*16 +: 16] = frame_bits[{word_cnt_q, 4'b0000} +: 16];
        end else begin
          tx_data_d[l*16 +: 16] = (word_cnt_q == '0) ? IDLE_WORD0 : 16'h0000;
        end
        tx_isk_d[l*2 +: 2] = (word_cnt_q == '0) ? 2'b01 : 2'b00;
      end
      if ((state_q == ST_RUN) && (word_cnt_q == '0) && (sep == 8'hFC))
        overflow_cnt_d = sat_inc16(overflow_cnt_q);
    end
  end

  always_comb begin
    cap_data_d     = data_rd_q ? data_i     : cap_data_q;
    cap_bc0_d      = data_rd_q ? bc0_i      : cap_bc0_q;
    cap_resync_d   = data_rd_q ? resync_i   : cap_resync_q;
    cap_overflow_d = data_rd_q ? overflow_i : cap_overflow_q;
    cap_bxn_d      = data_rd_q ? bxn_lsbs_i : cap_bxn_q;
  end

  // Control and output registers
  always_ff @(posedge clock_160 or posedge reset_i) begin
    if (reset_i) begin
      state_q        <= ST_WAIT;
      word_cnt_q     <= '0;
      idle_cnt_q     <= '0;
      frame_cnt_q    <= '0;
      data_rd_q      <= 1'b0;
      frame_start_q  <= 1'b0;
      overflow_cnt_q <= '0;
      tx_data_q      <= {NUM_LINKS{DOWN_WORD}};
      tx_isk_q       <= {NUM_LINKS{2'b01}};
    end else begin
      state_q        <= state_d;
      word_cnt_q     <= word_cnt_d;
      idle_cnt_q     <= idle_cnt_d;
      frame_cnt_q    <= frame_cnt_d;
      data_rd_q      <= data_rd_d;
      frame_start_q  <= frame_start_d;
      overflow_cnt_q <= overflow_cnt_d;
      tx_data_q      <= tx_data_d;
      tx_isk_q       <= tx_isk_d;
    end
  end

  // Upstream word capture
  always_ff @(posedge clock_160) begin
    cap_data_q     <= cap_data_d;
    cap_bc0_q      <= cap_bc0_d;
    cap_resync_q   <= cap_resync_d;
    cap_overflow_q <= cap_overflow_d;
    cap_bxn_q      <= cap_bxn_d;
  end

  assign data_rd_o      = data_rd_q;
  assign tx_data_o      = tx_data_q;
  assign tx_isk_o       = tx_isk_q;
  assign state_o        = state_q;
  assign frame_start_o  = frame_start_q;
  assign overflow_cnt_o = overflow_cnt_q;

endmodule

// File: tb/tb_gem_link_framer.sv
// ---------------------------------------------------------------------------
// tb_gem_link_framer
//
// Directed bench for gem_link_framer (4 lanes, 4-word frames, 3 idle frames,
// separator rotation from the local frame counter). A frame-level model
// predicts every output each cycle; hand-computed literals pin key words.
// ---------------------------------------------------------------------------
module tb_gem_link_framer;

  localparam int NL   = 4;
  localparam int FW   = 4;
  localparam int DB   = 16*FW-8;
  localparam int IDLE = 3;
  localparam int TB_CTRL_TTC = 0;

  logic              clk;
  logic              rst;
  logic              link_ready_i;
  logic [NL-1:0]     link_en_i;
  logic [NL*DB-1:0]  data_i;
  logic              bc0_i;
  logic              resync_i;
  logic              overflow_i;
  logic [1:0]        bxn_lsbs_i;
  logic              data_rd_o;
  logic [NL*16-1:0]  tx_data_o;
  logic [NL*2-1:0]   tx_isk_o;
  logic [1:0]        state_o;
  logic              frame_start_o;
  logic [15:0]       overflow_cnt_o;

  gem_link_framer #(
    .NUM_LINKS      (NL),
    .FRAME_WORDS    (FW),
    .ALLOW_TTC_CHARS(1),
    .FRAME_CTRL_TTC (TB_CTRL_TTC),
    .IDLE_FRAMES    (IDLE)
  ) dut (
    .clock_160     (clk),
    .reset_i       (rst),
    .link_ready_i  (link_ready_i),
    .link_en_i     (link_en_i),
    .data_i        (data_i),
    .bc0_i         (bc0_i),
    .resync_i      (resync_i),
    .overflow_i    (overflow_i),
    .bxn_lsbs_i    (bxn_lsbs_i),
    .data_rd_o     (data_rd_o),
    .tx_data_o     (tx_data_o),
    .tx_isk_o      (tx_isk_o),
    .state_o       (state_o),
    .frame_start_o (frame_start_o),
    .overflow_cnt_o(overflow_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- frame-level model ----------------
  int          m_phase;   // 0 wait, 1 training, 2 running
  int          m_pos;     // word index within the current frame
  int          m_idle;    // training frames completed
  int          m_fcnt;    // running frames completed
  logic [DB-1:0] m_cap [NL];
  logic        m_bc0, m_rsy, m_ovf;
  logic [1:0]  m_bxn;
  logic [NL*16-1:0] e_tx;
  logic [NL*2-1:0]  e_isk;
  logic        e_fs, e_rd;
  logic [1:0]  e_state;
  logic [15:0] e_ovf;

  function automatic logic [7:0] model_sep(input logic bc0, input logic rsy,
                                           input logic ovf, input int sel);
    if (bc0) return 8'h1C;
    if (rsy) return 8'h3C;
    if (ovf) return 8'hFC;
    case (sel % 4)
      0:       return 8'hBC;
      1:       return 8'hF7;
      2:       return 8'hFB;
      default: return 8'hFD;
    endcase
  endfunction

  task automatic model_reset();
    m_phase = 0; m_pos = 0; m_idle = 0; m_fcnt = 0;
    e_tx = {NL{16'hFFFC}}; e_isk = {NL{2'b01}};
    e_fs = 1'b0; e_rd = 1'b0; e_state = 2'd0; e_ovf = 16'h0000;
  endtask

  // Predicts the outputs after the coming clock edge from the inputs now applied.
  task automatic model_step();
    logic [7:0]       sep;
    logic [16*FW-1:0] fb;
    int               sel;
    sel = (TB_CTRL_TTC != 0) ? int'(m_bxn) : m_fcnt;
    sep = model_sep(m_bc0, m_rsy, m_ovf, sel);
    if (!link_ready_i || m_phase == 0) begin
      e_tx  = {NL{16'hFFFC}};
      e_isk = {NL{2'b01}};
      e_fs  = 1'b0;
    end else begin
      e_fs = (m_pos == 0);
      for (int l = 0; l < NL; l++) begin
        if (m_phase == 2 && link_en_i[l]) begin
          fb = {m_cap[l], sep};
          fb = fb >> (16*m_pos);
          e_tx[l*16 +: 16] = fb[15:0];
        end else begin
          e_tx[l*16 +: 16] = (m_pos == 0) ? 16'h50BC : 16'h0000;
        end
        e_isk[l*2 +: 2] = (m_pos == 0) ? 2'b01 : 2'b00;
      end
      if (m_phase == 2 && m_pos == 0 && sep == 8'hFC && e_ovf != 16'hFFFF)
        e_ovf = e_ovf + 16'd1;
    end
    if (e_rd) begin
      for (int l = 0; l < NL; l++) m_cap[l] = data_i[l*DB +: DB];
      m_bc0 = bc0_i; m_rsy = resync_i; m_ovf = overflow_i; m_bxn = bxn_lsbs_i;
    end
    if (!link_ready_i) begin
      m_phase = 0; m_pos = 0;
    end else if (m_phase == 0) begin
      m_phase = 1; m_pos = 0; m_idle = 0;
    end else if (m_pos == FW-1) begin
      m_pos = 0;
      if (m_phase == 1) begin
        m_idle++;
        if (m_idle == IDLE) begin m_phase = 2; m_fcnt = 0; end
      end else begin
        m_fcnt++;
      end
    end else begin
      m_pos++;
    end
    e_state = 2'(m_phase);
    e_rd = (m_phase != 0) && (m_pos == FW-1) && (m_phase == 2 || m_idle == IDLE-1);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("m_tx",    64'(tx_data_o),      64'(e_tx));
    chk("m_isk",   64'(tx_isk_o),       64'(e_isk));
    chk("m_fs",    64'(frame_start_o),  64'(e_fs));
    chk("m_rd",    64'(data_rd_o),      64'(e_rd));
    chk("m_state", 64'(state_o),        64'(e_state));
    chk("m_ovf",   64'(overflow_cnt_o), 64'(e_ovf));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #2;
    compare_all();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1; link_ready_i = 1'b0; link_en_i = 4'hF;
    data_i = '0; bc0_i = 1'b0; resync_i = 1'b0; overflow_i = 1'b0; bxn_lsbs_i = 2'd0;
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    chk("rst_tx",    64'(tx_data_o),      64'hFFFC_FFFC_FFFC_FFFC);
    chk("rst_isk",   64'(tx_isk_o),       64'h55);
    chk("rst_state", 64'(state_o),        64'd0);
    chk("rst_rd",    64'(data_rd_o),      64'd0);
    chk("rst_ovf",   64'(overflow_cnt_o), 64'd0);
    rst = 1'b0;
    tick(); tick();
    chk("wait_hold", 64'(state_o), 64'd0);

    data_i = {56'hB0B1B2B3B4B5B6, 56'hA0A1A2A3A4A5A6,
              56'h11223344556677, 56'h0123456789ABCD};
    link_ready_i = 1'b1;

    for (int n = 1; n <= 81; n++) begin
      tick();
      case (n)
        1:  begin chk("train_state", 64'(state_o), 64'd1);
                  chk("train_first", 64'(tx_data_o[15:0]), 64'hFFFC); end
        2:  begin chk("idle_w0", 64'(tx_data_o), 64'h50BC_50BC_50BC_50BC);
                  chk("idle_k0", 64'(tx_isk_o), 64'h55);
                  chk("idle_fs", 64'(frame_start_o), 64'd1); end
        3:  begin chk("idle_w1", 64'(tx_data_o), 64'd0);
                  chk("idle_k1", 64'(tx_isk_o), 64'd0); end
        11: chk("rd_early", 64'(data_rd_o), 64'd0);
        12: chk("rd_last_train", 64'(data_rd_o), 64'd1);
        13: chk("run_state", 64'(state_o), 64'd2);
        14: begin chk("run_w0_l0", 64'(tx_data_o[15:0]), 64'hCDBC);
                  chk("run_k0_l0", 64'(tx_isk_o[1:0]), 64'h1);
                  chk("run_w0_l1", 64'(tx_data_o[31:16]), 64'h77BC); end
        15: chk("run_w1_l0", 64'(tx_data_o[15:0]), 64'h89AB);
        16: chk("run_w2_l0", 64'(tx_data_o[15:0]), 64'h4567);
        17: begin chk("run_w3_l0", 64'(tx_data_o[15:0]), 64'h0123);
                  chk("run_k3_l0", 64'(tx_isk_o[1:0]), 64'h0); end
        18: chk("sep_f7", 64'(tx_data_o[15:0]), 64'hCDF7);
        22: chk("sep_fb", 64'(tx_data_o[15:0]), 64'hCDFB);
        26: chk("sep_fd", 64'(tx_data_o[15:0]), 64'hCDFD);
        30: chk("sep_bc", 64'(tx_data_o[15:0]), 64'hCDBC);
        32: begin bc0_i = 1'b1; resync_i = 1'b1; overflow_i = 1'b1; end
        33: begin bc0_i = 1'b0; resync_i = 1'b0; end
        34: begin chk("sep_bc0", 64'(tx_data_o[15:0]), 64'hCD1C);
                  chk("ovf_zero", 64'(overflow_cnt_o), 64'd0); end
        37: overflow_i = 1'b0;
        38: begin chk("sep_ovf", 64'(tx_data_o[15:0]), 64'hCDFC);
                  chk("ovf_one", 64'(overflow_cnt_o), 64'd1); end
        42: chk("sep_after", 64'(tx_data_o[15:0]), 64'hCDFD);
        43: begin force dut.overflow_cnt_q = 16'hFFFE; e_ovf = 16'hFFFE; end
        44: begin release dut.overflow_cnt_q; overflow_i = 1'b1; end
        46: chk("ovf_to_max", 64'(overflow_cnt_o), 64'hFFFF);
        49: overflow_i = 1'b0;
        50: begin chk("ovf_sat", 64'(overflow_cnt_o), 64'hFFFF);
                  chk("ovf_sep", 64'(tx_data_o[15:0]), 64'hCDFC); end
        53: link_en_i = 4'b1010;
        54: begin chk("mask_w0", 64'(tx_data_o), 64'hB6FB_50BC_77FB_50BC);
                  chk("mask_fs", 64'(frame_start_o), 64'd1); end
        55: chk("mask_w1", 64'(tx_data_o), 64'hB4B5_0000_5566_0000);
        59: link_ready_i = 1'b0;
        60: begin chk("drop_tx", 64'(tx_data_o), 64'hFFFC_FFFC_FFFC_FFFC);
                  chk("drop_isk", 64'(tx_isk_o), 64'h55);
                  chk("drop_state", 64'(state_o), 64'd0);
                  chk("drop_rd", 64'(data_rd_o), 64'd0);
                  chk("drop_ovf", 64'(overflow_cnt_o), 64'hFFFF); end
        62: begin link_ready_i = 1'b1; link_en_i = 4'hF; end
        64: begin chk("retrain_w0", 64'(tx_data_o), 64'h50BC_50BC_50BC_50BC);
                  chk("retrain_state", 64'(state_o), 64'd1); end
        70: chk("retrain_rd_early", 64'(data_rd_o), 64'd0);
        74: chk("retrain_rd", 64'(data_rd_o), 64'd1);
        75: chk("rerun_state", 64'(state_o), 64'd2);
        76: chk("rerun_w0", 64'(tx_data_o[15:0]), 64'hCDBC);
        81: chk("rerun_w1", 64'(tx_data_o[15:0]), 64'h89AB);
        default: ;
      endcase
    end

    // Asynchronous reset in the middle of a running frame.
    rst = 1'b1;
    #1;
    model_reset();
    chk("areset_tx",    64'(tx_data_o),      64'hFFFC_FFFC_FFFC_FFFC);
    chk("areset_isk",   64'(tx_isk_o),       64'h55);
    chk("areset_state", 64'(state_o),        64'd0);
    chk("areset_ovf",   64'(overflow_cnt_o), 64'd0);
    chk("areset_fs",    64'(frame_start_o),  64'd0);
    link_ready_i = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b0;
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
